// File: rtl/usb_ohci_dma_addr_ext.sv
// Extends the OHCI 32b DMA address space with a Regbus-programmable upper window.
// Window updates wait until every in-flight AW/AR burst has completed.
package usb_ohci_dma_addr_ext_pkg;
  localparam int unsigned IdW      = 4;
  localparam int unsigned SlvAddrW = 32;
  localparam int unsigned MstAddrW = 64;
  localparam int unsigned DataW    = 32;
  localparam int unsigned StrbW    = DataW / 8;

  typedef struct packed {
    logic [IdW-1:0]      id;
    logic [SlvAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } slv_ax_t;

  typedef struct packed {
    logic [IdW-1:0]      id;
    logic [MstAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } mst_ax_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic             last;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_chan_t;

  typedef struct packed {
    slv_ax_t aw;
    logic    aw_valid;
    w_chan_t w;
    logic    w_valid;
    logic    b_ready;
    slv_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } slv_req_t;

  typedef struct packed {
    mst_ax_t aw;
    logic    aw_valid;
    w_chan_t w;
    logic    w_valid;
    logic    b_ready;
    mst_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } mst_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } axi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module usb_ohci_dma_addr_ext #(
  parameter int unsigned                  AxiAddrWidth = 64,
  parameter int unsigned                  MaxTxns      = 8,
  parameter logic [AxiAddrWidth-33:0]     RstHigh      = '0,
  parameter type reg_req_t = usb_ohci_dma_addr_ext_pkg::reg_req_t,
  parameter type reg_rsp_t = usb_ohci_dma_addr_ext_pkg::reg_rsp_t,
  parameter type slv_req_t = usb_ohci_dma_addr_ext_pkg::slv_req_t,
  parameter type slv_rsp_t = usb_ohci_dma_addr_ext_pkg::axi_rsp_t,
  parameter type mst_req_t = usb_ohci_dma_addr_ext_pkg::mst_req_t,
  parameter type mst_rsp_t = usb_ohci_dma_addr_ext_pkg::axi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  input  slv_req_t slv_req_i,
  output slv_rsp_t slv_rsp_o,
  output mst_req_t mst_req_o,
  input  mst_rsp_t mst_rsp_i
);
  localparam int unsigned HighW = AxiAddrWidth - 32;
  localparam int unsigned CntW  = $clog2(MaxTxns + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, UPDATE} state_e;

  state_e            state_q, state_d;
  logic              en_q, en_d;
  logic [HighW-1:0]  high_q, high_d;
  logic              sel_high_q, sel_high_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CntW-1:0]   aw_cnt_q, aw_cnt_d;
  logic [CntW-1:0]   ar_cnt_q, ar_cnt_d;

  logic aw_block, ar_block;
  logic aw_hs, ar_hs, b_hs, r_last_hs;
  logic aw_pend, ar_pend;
  logic is_ctrl, is_high, is_stat;
  logic [HighW-1:0] win;

  logic unused_ok;
  assign unused_ok = ^{reg_req_i.addr[31:4], reg_req_i.wstrb};

  // Channel gating: blocked while full, while a window change is in progress, or in reset.
  assign aw_block = !rst_ni || (state_q != IDLE) || (aw_cnt_q == CntW'(MaxTxns));
  assign ar_block = !rst_ni || (state_q != IDLE) || (ar_cnt_q == CntW'(MaxTxns));

  assign aw_hs     = slv_req_i.aw_valid && !aw_block && mst_rsp_i.aw_ready;
  assign ar_hs     = slv_req_i.ar_valid && !ar_block && mst_rsp_i.ar_ready;
  assign b_hs      = rst_ni && mst_rsp_i.b_valid && slv_req_i.b_ready;
  assign r_last_hs = rst_ni && mst_rsp_i.r_valid && slv_req_i.r_ready && mst_rsp_i.r.last;
  assign aw_pend   = slv_req_i.aw_valid && !aw_block && !mst_rsp_i.aw_ready;
  assign ar_pend   = slv_req_i.ar_valid && !ar_block && !mst_rsp_i.ar_ready;

  assign win = en_q ? high_q : {HighW{1'b0}};

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw.id    = slv_req_i.aw.id;
    mst_req_o.aw.addr  = {win, slv_req_i.aw.addr};
    mst_req_o.aw.len   = slv_req_i.aw.len;
    mst_req_o.aw.size  = slv_req_i.aw.size;
    mst_req_o.aw.burst = slv_req_i.aw.burst;
    mst_req_o.aw_valid = slv_req_i.aw_valid && !aw_block;
    mst_req_o.w        = slv_req_i.w;
    mst_req_o.w_valid  = slv_req_i.w_valid && rst_ni;
    mst_req_o.b_ready  = slv_req_i.b_ready && rst_ni;
    mst_req_o.ar.id    = slv_req_i.ar.id;
    mst_req_o.ar.addr  = {win, slv_req_i.ar.addr};
    mst_req_o.ar.len   = slv_req_i.ar.len;
    mst_req_o.ar.size  = slv_req_i.ar.size;
    mst_req_o.ar.burst = slv_req_i.ar.burst;
    mst_req_o.ar_valid = slv_req_i.ar_valid && !ar_block;
    mst_req_o.r_ready  = slv_req_i.r_ready && rst_ni;

    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready && !aw_block;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready && !ar_block;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready && rst_ni;
    slv_rsp_o.b_valid  = mst_rsp_i.b_valid && rst_ni;
    slv_rsp_o.r_valid  = mst_rsp_i.r_valid && rst_ni;
  end

  // Outstanding counters; a simultaneous request and response cancel out.
  always_comb begin
    aw_cnt_d = aw_cnt_q;
    ar_cnt_d = ar_cnt_q;
    if (aw_hs && !b_hs) begin
      aw_cnt_d = aw_cnt_q + CntW'(1);
    end else if (!aw_hs && b_hs && (aw_cnt_q != '0)) begin
      aw_cnt_d = aw_cnt_q - CntW'(1);
    end
    if (ar_hs && !r_last_hs) begin
      ar_cnt_d = ar_cnt_q + CntW'(1);
    end else if (!ar_hs && r_last_hs && (ar_cnt_q != '0)) begin
      ar_cnt_d = ar_cnt_q - CntW'(1);
    end
  end

  assign is_ctrl = (reg_req_i.addr[3:0] == 4'h0);
  assign is_high = (reg_req_i.addr[3:0] == 4'h4);
  assign is_stat = (reg_req_i.addr[3:0] == 4'h8);

  // Register access FSM; writes drain outstanding bursts before committing.
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    high_d     = high_q;
    sel_high_d = sel_high_q;
    wdata_d    = wdata_q;
    reg_rsp_o  = '0;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          if (reg_req_i.valid) begin
            if (!reg_req_i.write) begin
              reg_rsp_o.ready = 1'b1;
              if (is_ctrl) begin
                reg_rsp_o.rdata = {31'd0, en_q};
              end else if (is_high) begin
                reg_rsp_o.rdata = 32'(high_q);
              end else if (is_stat) begin
                reg_rsp_o.rdata = {16'd0, 8'(ar_cnt_q), 8'(aw_cnt_q)};
              end else begin
                reg_rsp_o.error = 1'b1;
              end
            end else if (!(is_ctrl || is_high)) begin
              reg_rsp_o.ready = 1'b1;
              reg_rsp_o.error = 1'b1;
            end else if (!aw_pend && !ar_pend) begin
              sel_high_d = is_high;
              wdata_d    = reg_req_i.wdata;
              state_d    = DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((aw_cnt_q == '0) && (ar_cnt_q == '0)) begin
            state_d = UPDATE;
          end
        end
        UPDATE: begin
          reg_rsp_o.ready = 1'b1;
          if (sel_high_q) begin
            high_d = wdata_q[HighW-1:0];
          end else begin
            en_d = wdata_q[0];
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      high_q     <= RstHigh;
      sel_high_q <= 1'b0;
      wdata_q    <= '0;
      aw_cnt_q   <= '0;
      ar_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      high_q     <= high_d;
      sel_high_q <= sel_high_d;
      wdata_q    <= wdata_d;
      aw_cnt_q   <= aw_cnt_d;
      ar_cnt_q   <= ar_cnt_d;
    end
  end

  // A response with nothing outstanding is an upstream protocol violation.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(b_hs && !aw_hs && (aw_cnt_q == '0)))
    else $error("B response with no outstanding AW");
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_last_hs && !ar_hs && (ar_cnt_q == '0)))
    else $error("R last with no outstanding AR");
endmodule

// File: tb/tb_usb_ohci_dma_addr_ext.sv
// Directed bench for usb_ohci_dma_addr_ext: register map, address window, drain and counters.
module tb_usb_ohci_dma_addr_ext;
  import usb_ohci_dma_addr_ext_pkg::*;

  logic     clk;
  logic     rst_n;
  reg_req_t reg_req;
  reg_rsp_t reg_rsp;
  slv_req_t slv_req;
  axi_rsp_t slv_rsp;
  mst_req_t mst_req;
  axi_rsp_t mst_rsp;

  int n_checks = 0;
  int n_errors = 0;

  usb_ohci_dma_addr_ext #(
    .AxiAddrWidth(64),
    .MaxTxns     (8),
    .RstHigh     (32'h0000_00A5)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .reg_req_i(reg_req),
    .reg_rsp_o(reg_rsp),
    .slv_req_i(slv_req),
    .slv_rsp_o(slv_rsp),
    .mst_req_o(mst_req),
    .mst_rsp_i(mst_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    reg_req.addr  = a;
    reg_req.write = 1'b0;
    reg_req.valid = 1'b1;
    #1;
    check({tag, "_ready"}, 64'(reg_rsp.ready), 64'd1);
    check({tag, "_err"}, 64'(reg_rsp.error), 64'd0);
    check(tag, 64'(reg_rsp.rdata), 64'(exp));
    @(posedge clk);
    #1 reg_req.valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int cyc, output logic err);
    @(negedge clk);
    reg_req.addr  = a;
    reg_req.write = 1'b1;
    reg_req.wdata = d;
    reg_req.wstrb = 4'hF;
    reg_req.valid = 1'b1;
    cyc = 0;
    #1;
    while (!reg_rsp.ready && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    err = reg_rsp.error;
    @(posedge clk);
    #1 reg_req.valid = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic err;
    reg_req = '0;
    slv_req = '0;
    mst_rsp = '0;
    rst_n   = 1'b0;

    // Reset: handshake outputs held low even with upstream activity
    slv_req.aw_valid = 1'b1;
    slv_req.w_valid  = 1'b1;
    reg_req.valid    = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mst_aw_valid", 64'(mst_req.aw_valid), 64'd0);
    check("rst_mst_w_valid", 64'(mst_req.w_valid), 64'd0);
    check("rst_reg_ready", 64'(reg_rsp.ready), 64'd0);
    slv_req = '0;
    reg_req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    rd(32'h0, 32'h0, "rd_ctrl_rst");
    rd(32'h4, 32'hA5, "rd_high_rst");
    rd(32'h8, 32'h0, "rd_stat_rst");

    // Window programming with idle counters: ready two cycles after request
    wr(32'h0, 32'h1, cyc, err);
    check("wr_ctrl_lat", 64'(cyc), 64'd2);
    check("wr_ctrl_err", 64'(err), 64'd0);
    wr(32'h4, 32'h1, cyc, err);
    check("wr_high_lat", 64'(cyc), 64'd2);
    rd(32'h4, 32'h1, "rd_high_1");
    rd(32'h0, 32'h1, "rd_ctrl_1");

    @(negedge clk);
    slv_req.ar.addr  = 32'h8000_1000;
    slv_req.ar.id    = 4'h3;
    slv_req.ar.len   = 8'd7;
    slv_req.ar_valid = 1'b1;
    #1;
    check("ar_addr_en", mst_req.ar.addr, 64'h0000_0001_8000_1000);
    check("ar_valid_en", 64'(mst_req.ar_valid), 64'd1);
    check("ar_id_pass", 64'(mst_req.ar.id), 64'h3);
    check("ar_len_pass", 64'(mst_req.ar.len), 64'd7);
    @(negedge clk);
    slv_req.ar_valid = 1'b0;
    wr(32'h0, 32'h0, cyc, err);
    @(negedge clk);
    slv_req.ar_valid = 1'b1;
    #1;
    check("ar_addr_dis", mst_req.ar.addr, 64'h0000_0000_8000_1000);
    @(negedge clk);
    slv_req.ar_valid = 1'b0;
    wr(32'h0, 32'h1, cyc, err);

    // Three AWs outstanding, then a HIGH write must wait for their Bs
    mst_rsp.aw_ready = 1'b1;
    slv_req.aw.addr  = 32'h0000_4000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      slv_req.aw_valid = 1'b1;
      #1;
      check("aw_acc", 64'(slv_rsp.aw_ready), 64'd1);
    end
    @(negedge clk);
    slv_req.aw_valid = 1'b0;
    rd(32'h8, 32'h3, "rd_stat_aw3");

    @(negedge clk);
    reg_req.addr  = 32'h4;
    reg_req.write = 1'b1;
    reg_req.wdata = 32'h2;
    reg_req.valid = 1'b1;
    #1;
    check("drain_idle_ready", 64'(reg_rsp.ready), 64'd0);
    @(negedge clk);
    slv_req.aw.addr  = 32'h1234_0000;
    slv_req.aw_valid = 1'b1;
    slv_req.w_valid  = 1'b1;
    slv_req.w.data   = 32'hCAFE_F00D;
    mst_rsp.w_ready  = 1'b1;
    #1;
    check("drain_slv_aw_ready", 64'(slv_rsp.aw_ready), 64'd0);
    check("drain_mst_aw_valid", 64'(mst_req.aw_valid), 64'd0);
    check("drain_mst_w_valid", 64'(mst_req.w_valid), 64'd1);
    check("drain_w_data", 64'(mst_req.w.data), 64'hCAFE_F00D);
    check("drain_slv_w_ready", 64'(slv_rsp.w_ready), 64'd1);
    check("drain_reg_ready", 64'(reg_rsp.ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mst_rsp.b_valid = 1'b1;
      mst_rsp.b.id    = 4'h5;
      slv_req.b_ready = 1'b1;
      #1;
      check("drain_b_reg_ready", 64'(reg_rsp.ready), 64'd0);
      check("b_id_pass", 64'(slv_rsp.b.id), 64'h5);
    end
    @(negedge clk);
    mst_rsp.b_valid = 1'b0;
    slv_req.w_valid = 1'b0;
    #1;
    check("drain_last_ready", 64'(reg_rsp.ready), 64'd0);
    @(negedge clk);
    #1;
    check("update_ready", 64'(reg_rsp.ready), 64'd1);
    check("update_err", 64'(reg_rsp.error), 64'd0);
    check("update_aw_block", 64'(slv_rsp.aw_ready), 64'd0);
    @(posedge clk);
    #1 reg_req.valid = 1'b0;
    @(negedge clk);
    #1;
    check("post_aw_ready", 64'(slv_rsp.aw_ready), 64'd1);
    check("post_aw_addr", mst_req.aw.addr, 64'h0000_0002_1234_0000);
    @(negedge clk);
    slv_req.aw_valid = 1'b0;
    mst_rsp.b_valid  = 1'b1;
    @(negedge clk);
    mst_rsp.b_valid  = 1'b0;
    rd(32'h8, 32'h0, "rd_stat_aw0");
    rd(32'h4, 32'h2, "rd_high_2");

    // Fill AR to MaxTxns and exercise the full and cancel cases
    mst_rsp.ar_ready = 1'b1;
    slv_req.ar.addr  = 32'h0000_0100;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      slv_req.ar_valid = 1'b1;
      #1;
      check("ar_fill_ready", 64'(slv_rsp.ar_ready), 64'd1);
    end
    @(negedge clk);
    #1;
    check("ar_full_ready", 64'(slv_rsp.ar_ready), 64'd0);
    check("ar_full_mst_valid", 64'(mst_req.ar_valid), 64'd0);
    rd(32'h8, 32'h0800, "rd_stat_ar8");
    @(negedge clk);
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.last  = 1'b0;
    mst_rsp.r.data  = 32'h1111_2222;
    slv_req.r_ready = 1'b1;
    #1;
    check("r_data_pass", 64'(slv_rsp.r.data), 64'h1111_2222);
    check("r_nolast_block", 64'(slv_rsp.ar_ready), 64'd0);
    @(negedge clk);
    mst_rsp.r.last = 1'b1;
    #1;
    check("r_last_block", 64'(slv_rsp.ar_ready), 64'd0);
    @(negedge clk);
    mst_rsp.r_valid = 1'b0;
    #1;
    check("ar_9th_acc", 64'(slv_rsp.ar_ready), 64'd1);
    @(negedge clk);
    mst_rsp.r_valid = 1'b1;
    #1;
    check("ar_refull_block", 64'(slv_rsp.ar_ready), 64'd0);
    @(negedge clk);
    #1;
    check("ar_both_ready", 64'(slv_rsp.ar_ready), 64'd1);
    @(negedge clk);
    mst_rsp.r_valid  = 1'b0;
    slv_req.ar_valid = 1'b0;
    rd(32'h8, 32'h0700, "rd_stat_both");
    @(negedge clk);
    mst_rsp.r_valid = 1'b1;
    repeat (5) @(negedge clk);
    mst_rsp.r_valid = 1'b0;
    rd(32'h8, 32'h0200, "rd_stat_ar2");

    // Invalid offset: immediate error, no state change
    wr(32'hC, 32'hFFFF_FFFF, cyc, err);
    check("wr_bad_lat", 64'(cyc), 64'd0);
    check("wr_bad_err", 64'(err), 64'd1);
    rd(32'h0, 32'h1, "rd_ctrl_after_bad");
    rd(32'h4, 32'h2, "rd_high_after_bad");

    // Reset in DRAIN with two ARs outstanding
    @(negedge clk);
    reg_req.addr  = 32'h4;
    reg_req.write = 1'b1;
    reg_req.wdata = 32'h3;
    reg_req.valid = 1'b1;
    @(negedge clk);
    #1;
    check("drain_ar2_ready", 64'(reg_rsp.ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_drain_ready", 64'(reg_rsp.ready), 64'd0);
    reg_req.valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(32'h8, 32'h0, "rd_stat_rst2");
    rd(32'h4, 32'hA5, "rd_high_rst2");
    rd(32'h0, 32'h0, "rd_ctrl_rst2");
    @(negedge clk);
    mst_rsp.ar_ready = 1'b0;
    slv_req.ar.addr  = 32'h8000_1000;
    slv_req.ar_valid = 1'b1;
    #1;
    check("rst2_ar_addr", mst_req.ar.addr, 64'h0000_0000_8000_1000);
    check("rst2_ar_valid", 64'(mst_req.ar_valid), 64'd1);
    @(negedge clk);
    slv_req.ar_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
